// File: rtl/dist_bcd_conv_pkg.sv
// dist_bcd_conv_pkg
// Shared definitions for the distance binary-to-BCD converter and the
// downstream five-digit display driver.
//   - state_t      : converter FSM states
//   - NUM_DIGITS   : number of BCD digits produced
//   - BCD_W        : width of the packed BCD result
//   - *_DEFAULT    : default input width and clamp value
//   - *_IDX        : nibble position of each digit inside the packed BCD word
package dist_bcd_conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam int NUM_DIGITS      = 5;
    localparam int BCD_W           = 4 * NUM_DIGITS;
    localparam int DATA_W_DEFAULT  = 17;
    localparam int MAX_VAL_DEFAULT = 99999;

    // Nibble index of each digit, most significant first.
    localparam int HUNDRED_IDX   = 4;
    localparam int TEN_IDX       = 3;
    localparam int ONE_IDX       = 2;
    localparam int D_TEN_IDX     = 1;
    localparam int D_HUNDRED_IDX = 0;

endpackage

// File: rtl/dist_bcd_conv_bcd_add3.sv
// bcd_add3
// Combinational double-dabble correction for one BCD nibble: a nibble of
// 5 or more gets 3 added so that the following left shift carries into the
// next decimal digit.
//   nib_in  : current nibble value (0..9)
//   nib_out : corrected nibble
module bcd_add3 (
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    // Only nibbles 0..9 ever arrive here, so the sum stays within 4 bits.
    assign nib_out = (nib_in >= 4'd5) ? (nib_in + 4'd3) : nib_in;

endmodule

// File: rtl/dist_bcd_conv.sv
// dist_bcd_conv
// Sequential binary-to-BCD converter feeding the 7-segment display driver.
// The input distance (0.01 cm per LSB) is clamped to MAX_VAL, then converted
// one bit per clock using shift-and-add-3. The digit outputs are updated in
// a single edge once the conversion is complete.
//   CLK        : system clock
//   RST        : asynchronous, active-high reset
//   Dist_In    : binary distance, sampled when Dist_Valid is high in IDLE
//   Dist_Valid : one-cycle conversion request (ignored while Busy)
//   Busy       : conversion in progress
//   Done       : one-cycle pulse when the digit outputs update
//   Overflow   : last completed input exceeded MAX_VAL
//   Hundred..D_Hundred : BCD digits of the (clamped) distance
module dist_bcd_conv
    import dist_bcd_conv_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int MAX_VAL = MAX_VAL_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] Dist_In,
    input  logic              Dist_Valid,
    output logic              Busy,
    output logic              Done,
    output logic              Overflow,
    output logic [3:0]        Hundred,
    output logic [3:0]        Ten,
    output logic [3:0]        One,
    output logic [3:0]        D_Ten,
    output logic [3:0]        D_Hundred
);

    localparam int                CNT_W    = $clog2(DATA_W + 1);
    localparam logic [DATA_W-1:0] MAX_IN   = DATA_W'(MAX_VAL);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               overflow_q, overflow_d;
    logic [BCD_W-1:0]   digits_q, digits_d;

    // Per-digit add-3 correction applied before every shift.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        bcd_add3 u_add3 (
            .nib_in  (bcd_q[g*4 +: 4]),
            .nib_out (bcd_adj[g*4 +: 4])
        );
    end

    // Next-state logic: load on request, shift DATA_W times, then publish
    // all digits at once so the display never sees a partial result.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        bit_cnt_d  = bit_cnt_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        digits_d   = digits_q;

        case (state_q)
            ST_IDLE: begin
                if (Dist_Valid) begin
                    bin_d      = (Dist_In > MAX_IN) ? MAX_IN : Dist_In;
                    bcd_d      = '0;
                    bit_cnt_d  = '0;
                    ovf_pend_d = (Dist_In > MAX_IN);
                    busy_d     = 1'b1;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // The BCD MSB shifted out is always zero because the clamped
                // value fits in five decimal digits.
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                bit_cnt_d      = bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                digits_d   = bcd_q;
                overflow_d = ovf_pend_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset discards any result in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            bit_cnt_q  <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            digits_q   <= '0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            bit_cnt_q  <= bit_cnt_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            digits_q   <= digits_d;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Overflow  = overflow_q;
    assign Hundred   = digits_q[HUNDRED_IDX*4   +: 4];
    assign Ten       = digits_q[TEN_IDX*4       +: 4];
    assign One       = digits_q[ONE_IDX*4       +: 4];
    assign D_Ten     = digits_q[D_TEN_IDX*4     +: 4];
    assign D_Hundred = digits_q[D_HUNDRED_IDX*4 +: 4];

endmodule

// File: tb/tb_dist_bcd_conv.sv
// tb_dist_bcd_conv
// Self-checking bench for dist_bcd_conv. Expected digits come from a
// decimal split of min(value, 99999); timing expectations come from the
// documented 18-cycle latency.
module tb_dist_bcd_conv;

    logic        CLK;
    logic        RST;
    logic [16:0] Dist_In;
    logic        Dist_Valid;
    logic        Busy;
    logic        Done;
    logic        Overflow;
    logic [3:0]  Hundred, Ten, One, D_Ten, D_Hundred;

    int tests_run    = 0;
    int tests_failed = 0;
    int done_total   = 0;

    dist_bcd_conv dut (
        .CLK        (CLK),
        .RST        (RST),
        .Dist_In    (Dist_In),
        .Dist_Valid (Dist_Valid),
        .Busy       (Busy),
        .Done       (Done),
        .Overflow   (Overflow),
        .Hundred    (Hundred),
        .Ten        (Ten),
        .One        (One),
        .D_Ten      (D_Ten),
        .D_Hundred  (D_Hundred)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Count every Done pulse seen on a rising edge.
    always @(posedge CLK) begin
        if (Done === 1'b1) done_total++;
    end

    // Reference: clamp then split into decimal digits, packed as a number
    // hundred*10^4 + ... so one compare covers all five digits.
    function automatic int ref_digits(input int v);
        int c;
        c = (v > 99999) ? 99999 : v;
        return ((c / 10000) % 10) * 10000 + ((c / 1000) % 10) * 1000 +
               ((c / 100) % 10) * 100 + ((c / 10) % 10) * 10 + (c % 10);
    endfunction

    function automatic int dut_digits();
        return int'(Hundred) * 10000 + int'(Ten) * 1000 + int'(One) * 100 +
               int'(D_Ten) * 10 + int'(D_Hundred);
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Drives a one-cycle request starting now; returns 1 ns after the
    // sampling edge.
    task automatic pulse_valid(input int v);
        Dist_In    = 17'(v);
        Dist_Valid = 1'b1;
        step();
        Dist_Valid = 1'b0;
    endtask

    // Waits (bounded) for Done; reports cycles waited and Busy cycles seen.
    task automatic wait_done(output int cycles, output int busy_cnt,
                             output bit timed_out);
        cycles    = 0;
        busy_cnt  = 0;
        timed_out = 1'b0;
        while (Done !== 1'b1) begin
            if (Busy === 1'b1) busy_cnt++;
            if (cycles >= 100) begin
                timed_out = 1'b1;
                break;
            end
            step();
            cycles++;
        end
    endtask

    task automatic test_reset();
        int bad_cycles = 0;
        RST        = 1'b1;
        Dist_Valid = 1'b0;
        Dist_In    = '0;
        repeat (3) step();
        RST = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (Busy !== 1'b0 || Done !== 1'b0 || Overflow !== 1'b0) bad_cycles++;
        end
        tests_run++;
        if (bad_cycles != 0) begin
            tests_failed++;
            $display("[TB] FAIL reset_idle_flags: got %0d bad cycles, expected 0", bad_cycles);
        end
        tests_run++;
        if (dut_digits() !== 0) begin
            tests_failed++;
            $display("[TB] FAIL reset_digits: got %05d expected 00000", dut_digits());
        end
    endtask

    task automatic test_single_12345();
        int cyc, bcnt;
        bit to;
        pulse_valid(12345);
        wait_done(cyc, bcnt, to);
        tests_run++;
        if (to || cyc != 18) begin
            tests_failed++;
            $display("[TB] FAIL latency_12345: got %0d cycles (timeout=%0d), expected 18", cyc, to);
        end
        tests_run++;
        if (bcnt != 18) begin
            tests_failed++;
            $display("[TB] FAIL busy_len_12345: got %0d expected 18", bcnt);
        end
        tests_run++;
        if (dut_digits() !== ref_digits(12345) || Overflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL digits_12345: got %05d ovf=%0b expected %05d ovf=0",
                     dut_digits(), Overflow, ref_digits(12345));
        end
        step();
        tests_run++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL done_pulse_12345: got done=%0b busy=%0b expected 0 0", Done, Busy);
        end
    endtask

    task automatic test_boundaries();
        int vals[3] = '{0, 99999, 131071};
        int cyc, bcnt;
        bit to;
        for (int i = 0; i < 3; i++) begin
            step();
            pulse_valid(vals[i]);
            wait_done(cyc, bcnt, to);
            tests_run++;
            if (to || dut_digits() !== ref_digits(vals[i]) ||
                Overflow !== (vals[i] > 99999)) begin
                tests_failed++;
                $display("[TB] FAIL boundary_%0d: got %05d ovf=%0b expected %05d ovf=%0b",
                         vals[i], dut_digits(), Overflow, ref_digits(vals[i]),
                         vals[i] > 99999);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bcnt, extra_done;
        bit to;
        step();
        pulse_valid(500);
        repeat (4) step();
        // Fifth cycle of the busy window: this request must be dropped.
        pulse_valid(777);
        wait_done(cyc, bcnt, to);
        tests_run++;
        if (to || dut_digits() !== 500) begin
            tests_failed++;
            $display("[TB] FAIL ignore_busy: got %05d expected 00500", dut_digits());
        end
        // New request issued in the Done cycle.
        pulse_valid(4321);
        wait_done(cyc, bcnt, to);
        tests_run++;
        if (to || cyc != 18 || dut_digits() !== 4321) begin
            tests_failed++;
            $display("[TB] FAIL b2b_4321: got %05d after %0d cycles, expected 04321 after 18",
                     dut_digits(), cyc);
        end
        extra_done = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (Done === 1'b1) extra_done++;
        end
        tests_run++;
        if (extra_done != 0) begin
            tests_failed++;
            $display("[TB] FAIL no_queue: got %0d extra Done pulses, expected 0", extra_done);
        end
    endtask

    task automatic test_reset_abort();
        int cyc, bcnt;
        bit to;
        pulse_valid(12345);
        wait_done(cyc, bcnt, to);
        step();
        pulse_valid(67890);
        repeat (8) step();
        RST = 1'b1;
        #1;
        tests_run++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Overflow !== 1'b0 || dut_digits() !== 0) begin
            tests_failed++;
            $display("[TB] FAIL abort_reset: got busy=%0b done=%0b ovf=%0b digits=%05d expected all 0",
                     Busy, Done, Overflow, dut_digits());
        end
        repeat (2) step();
        RST = 1'b0;
        step();
        pulse_valid(250);
        wait_done(cyc, bcnt, to);
        tests_run++;
        if (to || cyc != 18 || dut_digits() !== 250 || Overflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL after_abort_250: got %05d after %0d cycles, expected 00250 after 18",
                     dut_digits(), cyc);
        end
    endtask

    task automatic test_random();
        int cyc, bcnt, v, start_done, accepted, errs;
        bit to;
        step();
        start_done = done_total;
        accepted   = 0;
        errs       = 0;
        for (int i = 0; i < 1000; i++) begin
            v = int'($urandom_range(0, 131071));
            pulse_valid(v);
            accepted++;
            wait_done(cyc, bcnt, to);
            tests_run++;
            if (to || dut_digits() !== ref_digits(v) || Overflow !== (v > 99999)) begin
                tests_failed++;
                errs++;
                if (errs <= 10)
                    $display("[TB] FAIL random_%0d: got %05d ovf=%0b expected %05d ovf=%0b",
                             v, dut_digits(), Overflow, ref_digits(v), v > 99999);
            end
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
        end
        repeat (3) step();
        tests_run++;
        if (done_total - start_done != accepted) begin
            tests_failed++;
            $display("[TB] FAIL done_count: got %0d expected %0d",
                     done_total - start_done, accepted);
        end
    endtask

    initial begin
        test_reset();
        test_single_12345();
        test_boundaries();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
